instr_mem_block: RTL and testbench

Parametrised, byte-addressed instruction memory. It returns a whole aligned block of instruction words after a fixed multi-cycle latency, using a BUSYWAIT stall handshake. It replaces the flat combinational 8x1024 instruction array used by the integrated CPU bench, and sits between the fetch stage (or a future instruction cache) and program storage. A byte-wide load port fills the memory before execution.

---
 rtl/instr_mem_block.sv | 121 ++++++++++++
 tb/tb_instr_mem_block.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_block.sv
// Byte-addressed instruction memory: returns one aligned block of words READ_LATENCY cycles after the request.
// Latency: READ_LATENCY BUSY cycles, then a one-cycle RESP with DATA_VALID; BUSYWAIT stalls the requester throughout.
// Backpressure: none accepted; the block is presented for exactly one cycle and READDATA holds until the next response.
module instr_mem_block #(
    parameter int ADDR_W          = 10,
    parameter int WORD_W          = 32,
    parameter int WORDS_PER_BLOCK = 4,
    parameter int READ_LATENCY    = 4
) (
    input  logic                              CLK,
    input  logic                              RESET,
    input  logic                              READ,
    input  logic [ADDR_W-1:0]                 ADDRESS,
    output logic                              BUSYWAIT,
    output logic [WORDS_PER_BLOCK*WORD_W-1:0] READDATA,
    output logic                              DATA_VALID,
    input  logic                              LOAD_EN,
    input  logic [ADDR_W-1:0]                 LOAD_ADDR,
    input  logic [7:0]                        LOAD_BYTE
);

    localparam int BYTES_PER_WORD = WORD_W / 8;
    localparam int BLOCK_BYTES    = WORDS_PER_BLOCK * BYTES_PER_WORD;
    localparam int BLOCK_W        = WORDS_PER_BLOCK * WORD_W;
    localparam int OFFSET_W       = $clog2(BLOCK_BYTES);
    localparam int CNT_W          = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam int DEPTH          = 2 ** ADDR_W;

    localparam logic [ADDR_W-1:0] BASE_MASK = {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};
    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(READ_LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0]    base_q, base_d;
    logic [BLOCK_W-1:0]   rdata_q, rdata_d;
    logic                 valid_q, valid_d;
    logic [BLOCK_W-1:0]   block_dat;
    logic                 busywait;
    logic                 load_we;

    logic [7:0] mem_q [DEPTH];

    // Loads only land while idle and out of reset; they win over a concurrent read request.
    assign load_we = (state_q == IDLE) && LOAD_EN && RESET;

    always_ff @(posedge CLK) begin
        if (load_we) begin
            mem_q[LOAD_ADDR] <= LOAD_BYTE;
        end
    end

    // Little-endian words laid end to end make the block a flat little-endian byte run.
    always_comb begin
        block_dat = '0;
        for (int i = 0; i < BLOCK_BYTES; i++) begin
            block_dat[8*i +: 8] = mem_q[base_q | ADDR_W'(i)];
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        base_d   = base_q;
        rdata_d  = rdata_q;
        valid_d  = 1'b0;
        busywait = 1'b0;
        case (state_q)
            IDLE: begin
                busywait = READ;
                if (READ && !LOAD_EN) begin
                    base_d  = ADDRESS & BASE_MASK;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                busywait = 1'b1;
                if (cnt_q == CNT_LAST) begin
                    rdata_d = block_dat;
                    valid_d = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RESET) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            base_q  <= '0;
            rdata_q <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            base_q  <= base_d;
            rdata_q <= rdata_d;
            valid_q <= valid_d;
        end
    end

    assign BUSYWAIT   = busywait;
    assign READDATA   = rdata_q;
    assign DATA_VALID = valid_q;

endmodule

// File: tb/tb_instr_mem_block.sv
// Randomized bench for instr_mem_block: a byte-array model predicts every returned block.
// Also exercises a small-parameter instance (16-bit words, 2 words per block, latency 1).
module tb_instr_mem_block;

    localparam int RL = 4;

    typedef logic [127:0] val_t;

    logic         clk;
    logic         reset_n;
    logic         rd;
    logic [9:0]   addr;
    logic         busy;
    logic [127:0] rdata;
    logic         dv;
    logic         ld_en;
    logic [9:0]   ld_addr;
    logic [7:0]   ld_byte;

    logic         s_rd;
    logic [9:0]   s_addr;
    logic         s_busy;
    logic [31:0]  s_rdata;
    logic         s_dv;
    logic         s_ld_en;
    logic [9:0]   s_ld_addr;
    logic [7:0]   s_ld_byte;

    logic [7:0]   model_mem [1024];
    logic [127:0] last_rd;
    logic [127:0] got;
    int           n_checks = 0;
    int           n_fail   = 0;

    instr_mem_block #(
        .ADDR_W(10), .WORD_W(32), .WORDS_PER_BLOCK(4), .READ_LATENCY(RL)
    ) dut (
        .CLK(clk), .RESET(reset_n), .READ(rd), .ADDRESS(addr),
        .BUSYWAIT(busy), .READDATA(rdata), .DATA_VALID(dv),
        .LOAD_EN(ld_en), .LOAD_ADDR(ld_addr), .LOAD_BYTE(ld_byte)
    );

    instr_mem_block #(
        .ADDR_W(10), .WORD_W(16), .WORDS_PER_BLOCK(2), .READ_LATENCY(1)
    ) dut_small (
        .CLK(clk), .RESET(reset_n), .READ(s_rd), .ADDRESS(s_addr),
        .BUSYWAIT(s_busy), .READDATA(s_rdata), .DATA_VALID(s_dv),
        .LOAD_EN(s_ld_en), .LOAD_ADDR(s_ld_addr), .LOAD_BYTE(s_ld_byte)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: time limit reached before end of test");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input val_t obs, input val_t exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Word k, byte j of the block comes from base + 4k + j.
    function automatic logic [127:0] model_block(input logic [9:0] a);
        logic [127:0] r;
        logic [9:0]   base;
        base = a & 10'h3F0;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            for (int j = 0; j < 4; j++) begin
                r[k*32 + 8*j +: 8] = model_mem[base + 10'(k*4 + j)];
            end
        end
        return r;
    endfunction

    task automatic load_byte(input logic [9:0] a, input logic [7:0] b, input logic with_read);
        @(negedge clk);
        ld_en   = 1'b1;
        ld_addr = a;
        ld_byte = b;
        rd      = with_read;
        addr    = 10'($urandom);
        #1;
        check("load_busywait", val_t'(busy), val_t'(with_read));
        check("load_dv", val_t'(dv), 0);
        model_mem[a] = b;
    endtask

    // busy_mode 1 drives a 0xAA load to address 0 in every BUSY cycle; 0 drives random junk.
    task automatic run_read(input logic [9:0] a, input logic hold, input int busy_mode,
                            output logic [127:0] res);
        logic [127:0] exp;
        @(negedge clk);
        rd    = 1'b1;
        addr  = a;
        ld_en = 1'b0;
        #1;
        check("req_busywait", val_t'(busy), 1);
        check("req_dv", val_t'(dv), 0);
        check("hold_data", rdata, last_rd);
        exp = model_block(a);
        for (int i = 0; i < RL; i++) begin
            @(negedge clk);
            rd   = hold ? 1'b1 : 1'($urandom_range(0, 1));
            addr = 10'($urandom);
            if (busy_mode == 1) begin
                ld_en   = 1'b1;
                ld_addr = 10'h000;
                ld_byte = 8'hAA;
            end else begin
                ld_en   = 1'($urandom_range(0, 1));
                ld_addr = 10'($urandom);
                ld_byte = 8'($urandom);
            end
            #1;
            check("busy_busywait", val_t'(busy), 1);
            check("busy_dv", val_t'(dv), 0);
        end
        @(negedge clk);
        rd      = hold;
        ld_en   = 1'($urandom_range(0, 1));
        ld_addr = 10'($urandom);
        ld_byte = 8'($urandom);
        #1;
        check("resp_busywait", val_t'(busy), 0);
        check("resp_dv", val_t'(dv), 1);
        check("resp_data", rdata, exp);
        last_rd = exp;
        res     = rdata;
    endtask

    initial begin
        reset_n   = 1'b0;
        rd        = 1'b0;
        addr      = '0;
        ld_en     = 1'b0;
        ld_addr   = '0;
        ld_byte   = '0;
        s_rd      = 1'b0;
        s_addr    = '0;
        s_ld_en   = 1'b0;
        s_ld_addr = '0;
        s_ld_byte = '0;
        last_rd   = '0;

        // Reset state
        repeat (3) @(negedge clk);
        #1;
        check("rst_dv", val_t'(dv), 0);
        check("rst_data", rdata, 0);
        check("rst_busywait_lo", val_t'(busy), 0);
        rd = 1'b1;
        #1;
        check("rst_busywait_hi", val_t'(busy), 1);
        @(negedge clk);
        reset_n = 1'b1;
        rd      = 1'b0;
        #1;
        check("rst_no_accept", val_t'(busy), 0);

        // Fill everything so no X reaches the comparisons, then the directed program bytes
        for (int i = 0; i < 1024; i++) load_byte(10'(i), 8'($urandom), 1'b0);
        load_byte(10'h000, 8'h05, 1'b0);
        load_byte(10'h001, 8'h00, 1'b0);
        load_byte(10'h002, 8'h04, 1'b0);
        load_byte(10'h003, 8'h00, 1'b0);
        load_byte(10'h004, 8'h09, 1'b0);
        load_byte(10'h005, 8'h00, 1'b0);
        load_byte(10'h006, 8'h02, 1'b0);
        load_byte(10'h007, 8'h00, 1'b0);

        run_read(10'h000, 1'b0, 0, got);
        check("dir_w0", val_t'(got[31:0]), val_t'(32'h00040005));
        check("dir_w1", val_t'(got[63:32]), val_t'(32'h00020009));

        run_read(10'h00D, 1'b0, 0, got);
        check("unaligned_w0", val_t'(got[31:0]), val_t'(32'h00040005));
        check("unaligned_w1", val_t'(got[63:32]), val_t'(32'h00020009));

        // Back-to-back: READ held high through the response
        run_read(10'h000, 1'b1, 0, got);
        run_read(10'h010, 1'b0, 0, got);

        // Reset on the second BUSY cycle abandons the read
        @(negedge clk);
        rd    = 1'b1;
        addr  = 10'h000;
        ld_en = 1'b0;
        #1;
        check("mid_req_busywait", val_t'(busy), 1);
        @(negedge clk);
        #1;
        check("mid_busy1", val_t'(busy), 1);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        @(negedge clk);
        reset_n = 1'b1;
        rd      = 1'b0;
        #1;
        check("mid_busywait", val_t'(busy), 0);
        check("mid_dv", val_t'(dv), 0);
        check("mid_data", rdata, 0);
        last_rd = '0;
        for (int i = 0; i < RL + 2; i++) begin
            @(negedge clk);
            #1;
            check("mid_no_pulse", val_t'(dv), 0);
        end
        run_read(10'h000, 1'b0, 0, got);
        check("retained_w0", val_t'(got[31:0]), val_t'(32'h00040005));

        // Loads during BUSY/RESP are dropped
        run_read(10'h000, 1'b0, 1, got);
        @(negedge clk);
        ld_en = 1'b0;
        rd    = 1'b0;
        run_read(10'h000, 1'b0, 0, got);
        check("busy_load_w0", val_t'(got[31:0]), val_t'(32'h00040005));

        // Load and read together in IDLE: load wins, read follows
        load_byte(10'h000, 8'hAA, 1'b1);
        run_read(10'h000, 1'b0, 0, got);
        check("ld_rd_w0", val_t'(got[31:0]), val_t'(32'h000400AA));

        // Random mix of loads (possibly with READ asserted) and reads
        for (int it = 0; it < 80; it++) begin
            if ($urandom_range(0, 2) == 0) begin
                load_byte(10'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
            end else begin
                run_read(10'($urandom), 1'($urandom_range(0, 1)), 0, got);
            end
        end
        @(negedge clk);
        rd    = 1'b0;
        ld_en = 1'b0;

        // Small configuration: 16-bit words, 2 words per block, latency 1
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            s_ld_en   = 1'b1;
            s_ld_addr = 10'(i);
            s_ld_byte = 8'(8'h11 * (i + 1));
            #1;
            check("s_load_busywait", val_t'(s_busy), 0);
        end
        @(negedge clk);
        s_ld_en = 1'b0;
        s_rd    = 1'b1;
        s_addr  = 10'h000;
        #1;
        check("s_req_busywait", val_t'(s_busy), 1);
        check("s_req_dv", val_t'(s_dv), 0);
        @(negedge clk);
        s_rd = 1'b0;
        #1;
        check("s_busy_busywait", val_t'(s_busy), 1);
        check("s_busy_dv", val_t'(s_dv), 0);
        @(negedge clk);
        #1;
        check("s_resp_dv", val_t'(s_dv), 1);
        check("s_resp_busywait", val_t'(s_busy), 0);
        check("s_resp_data", val_t'(s_rdata), val_t'(32'h44332211));
        @(negedge clk);
        #1;
        check("s_idle_dv", val_t'(s_dv), 0);
        check("s_idle_data", val_t'(s_rdata), val_t'(32'h44332211));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
